// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - write-port arbiter, clear engine and read scanner for a two-port RAM
//
// Shares the RAM write port between two level-request / grant-pulse
// requesters and a clear engine that fills every word with one value. The
// read port is stepped through all addresses once every TICK_DIV enabled
// cycles, and each word is captured RD_LAT cycles after its address is issued.
//
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   scan_en                            read scanner advance enable
//   clear_start, fill_value            clear start pulse and fill word
//   req0/addr0/data0, gnt0             requester 0 request and grant pulse
//   req1/addr1/data1, gnt1             requester 1 request and grant pulse
//   busy, clear_done                   clear in progress / pulse after the last clear write
//   ram_wren, ram_wraddress, ram_data  RAM write port
//   ram_rdaddress, ram_q               RAM read port
//   rd_data, rd_valid                  captured read word and its update pulse
//
// Optional: define RD_BYPASS_EN to forward a write that hits the address being
// read, between the address update and the capture, into rd_data.

module ram_access_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int TICK_DIV = 50000000,
   parameter int RD_LAT   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              scan_en,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt1,
   output logic              busy,
   output logic              clear_done,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_wraddress,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_rdaddress,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;   // next word the clear engine writes
   logic [DATA_W-1:0] fill_q, fill_nxt;
   logic              pref1, pref1_nxt;         // 1: requester 1 wins a tie

   logic              elig0, elig1, any_req, pick1;
   logic              wren_d, gnt0_d, gnt1_d, busy_d, done_d;
   logic [ADDR_W-1:0] wraddr_d;
   logic [DATA_W-1:0] wdata_d;

   // A requester granted this cycle still shows its stale request; skip it.
   assign elig0   = req0 & ~gnt0;
   assign elig1   = req1 & ~gnt1;
   assign any_req = elig0 | elig1;
   assign pick1   = elig1 & (~elig0 | pref1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         clr_addr <= '0;
         fill_q   <= '0;
         pref1    <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         fill_q   <= fill_nxt;
         pref1    <= pref1_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      fill_nxt     = fill_q;
      pref1_nxt    = pref1;
      case (state)
         S_IDLE: begin
            if (clear_start) begin
               state_nxt    = S_CLEAR;
               clr_addr_nxt = ADDR_W'(1);   // word 0 goes out on the way in
               fill_nxt     = fill_value;
            end else if (any_req) begin
               pref1_nxt = ~pick1;
            end
         end
         S_CLEAR: begin
            clr_addr_nxt = clr_addr + 1'b1;
            if (clr_addr == '1) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered write-port and status outputs.
   always_comb begin
      wren_d   = 1'b0;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      wraddr_d = '0;
      wdata_d  = '0;
      case (state)
         S_IDLE: begin
            if (clear_start) begin
               busy_d  = 1'b1;
               wren_d  = 1'b1;
               wdata_d = fill_value;
            end else if (any_req) begin
               wren_d   = 1'b1;
               gnt0_d   = ~pick1;
               gnt1_d   = pick1;
               wraddr_d = pick1 ? addr1 : addr0;
               wdata_d  = pick1 ? data1 : data0;
            end
         end
         S_CLEAR: begin
            busy_d   = 1'b1;
            wren_d   = 1'b1;
            wraddr_d = clr_addr;
            wdata_d  = fill_q;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ram_wren      <= 1'b0;
         ram_wraddress <= '0;
         ram_data      <= '0;
         gnt0          <= 1'b0;
         gnt1          <= 1'b0;
         busy          <= 1'b0;
         clear_done    <= 1'b0;
      end else begin
         ram_wren      <= wren_d;
         ram_wraddress <= wraddr_d;
         ram_data      <= wdata_d;
         gnt0          <= gnt0_d;
         gnt1          <= gnt1_d;
         busy          <= busy_d;
         clear_done    <= done_d;
      end
   end

   // Read scanner
   logic [TICK_W-1:0] tick;
   logic              scan_step;
   logic [RD_LAT:0]   pend;       // bit k: the read address moved k cycles ago
   logic [DATA_W-1:0] cap_word;

   assign scan_step = scan_en && (tick == TICK_W'(TICK_DIV - 1));

`ifdef RD_BYPASS_EN
   logic              byp_hit;
   logic [DATA_W-1:0] byp_data;
   logic              wr_match;

   // Only one capture can be in flight since TICK_DIV > RD_LAT.
   assign wr_match = ram_wren && (ram_wraddress == ram_rdaddress) && (|pend);
   assign cap_word = wr_match ? ram_data : (byp_hit ? byp_data : ram_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         byp_hit  <= 1'b0;
         byp_data <= '0;
      end else if (pend[RD_LAT]) begin
         byp_hit  <= 1'b0;
      end else if (wr_match) begin
         byp_hit  <= 1'b1;
         byp_data <= ram_data;
      end
   end
`else
   assign cap_word = ram_q;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         tick          <= '0;
         ram_rdaddress <= '0;
         pend          <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
      end else begin
         if (scan_en) begin
            tick <= scan_step ? '0 : tick + 1'b1;
         end
         if (scan_step) begin
            ram_rdaddress <= ram_rdaddress + 1'b1;
         end
         pend     <= {pend[RD_LAT-1:0], scan_step};
         rd_valid <= pend[RD_LAT];
         if (pend[RD_LAT]) begin
            rd_data <= cap_word;
         end
      end
   end

endmodule
